// File: rtl/pb_cluster_boot_ctrl.sv
// Cluster boot sequencer: staggers clock enable and reset release per masked cluster,
// waits for each cluster's ready with a timeout, and raises a completion interrupt.
module pb_cluster_boot_ctrl #(
    parameter int unsigned NumClusters   = 16,
    parameter int unsigned StaggerCycles = 8,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [NumClusters-1:0] en_mask_i,
    input  logic [NumClusters-1:0] cluster_ready_i,
    output logic [NumClusters-1:0] cluster_clk_en_o,
    output logic [NumClusters-1:0] cluster_rst_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [NumClusters-1:0] err_mask_o,
    output logic                   irq_o,
    input  logic                   irq_clr_i
);

    localparam int unsigned IdxW        = (NumClusters > 1) ? $clog2(NumClusters) : 1;
    localparam logic [7:0]  StaggerLast = 8'(StaggerCycles - 1);
    localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClkEn,
        StRelease,
        StWaitReady,
        StNext,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [NumClusters-1:0] mask_q, mask_d;
    logic [NumClusters-1:0] clk_en_q, clk_en_d;
    logic [NumClusters-1:0] crst_q, crst_d;
    logic [NumClusters-1:0] err_q, err_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [7:0]             scnt_q, scnt_d;
    logic [15:0]            tcnt_q, tcnt_d;
    logic                   irq_q, irq_d;

    logic [NumClusters-1:0] cand;
    logic                   cand_found;
    logic [IdxW-1:0]        cand_idx;

    // Lowest pending cluster: from the incoming mask in idle, else above the current index.
    always_comb begin
        cand = '0;
        for (int i = 0; i < int'(NumClusters); i++) begin
            if (state_q == StIdle) begin
                cand[i] = en_mask_i[i];
            end else begin
                cand[i] = mask_q[i] && (IdxW'(i) > idx_q);
            end
        end
        cand_found = |cand;
        cand_idx   = '0;
        for (int i = int'(NumClusters) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                cand_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        clk_en_d = clk_en_q;
        crst_d   = crst_q;
        err_d    = err_q;
        idx_d    = idx_q;
        scnt_d   = scnt_q;
        tcnt_d   = tcnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    mask_d   = en_mask_i;
                    crst_d   = crst_q | en_mask_i;
                    clk_en_d = clk_en_q & ~en_mask_i;
                    err_d    = err_q & ~en_mask_i;
                    if (cand_found) begin
                        idx_d              = cand_idx;
                        clk_en_d[cand_idx] = 1'b1;
                        scnt_d             = '0;
                        state_d            = StClkEn;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StClkEn: begin
                if (scnt_q == StaggerLast) begin
                    crst_d[idx_q] = 1'b0;
                    state_d       = StRelease;
                end else begin
                    scnt_d = scnt_q + 8'd1;
                end
            end
            StRelease: begin
                tcnt_d  = '0;
                state_d = StWaitReady;
            end
            StWaitReady: begin
                // Ready is checked first so it wins over a coincident timeout.
                if (cluster_ready_i[idx_q]) begin
                    state_d = StNext;
                end else if (tcnt_q == TimeoutLast) begin
                    err_d[idx_q]    = 1'b1;
                    crst_d[idx_q]   = 1'b1;
                    clk_en_d[idx_q] = 1'b0;
                    state_d         = StNext;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            StNext: begin
                if (cand_found) begin
                    idx_d              = cand_idx;
                    clk_en_d[cand_idx] = 1'b1;
                    scnt_d             = '0;
                    state_d            = StClkEn;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        irq_d = (state_q == StDone) | (irq_q & ~irq_clr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            mask_q   <= '0;
            clk_en_q <= '0;
            crst_q   <= '1;
            err_q    <= '0;
            idx_q    <= '0;
            scnt_q   <= '0;
            tcnt_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            clk_en_q <= clk_en_d;
            crst_q   <= crst_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            scnt_q   <= scnt_d;
            tcnt_q   <= tcnt_d;
            irq_q    <= irq_d;
        end
    end

    assign cluster_clk_en_o = clk_en_q;
    assign cluster_rst_o    = crst_q;
    assign err_mask_o       = err_q;
    assign irq_o            = irq_q;
    assign busy_o           = (state_q != StIdle);
    assign done_o           = (state_q == StDone);

endmodule

// File: tb/tb_pb_cluster_boot_ctrl.sv
// Bench for pb_cluster_boot_ctrl: a timeline model predicts every output each cycle,
// while small cluster models answer reset release with ready after a chosen latency.
module tb_pb_cluster_boot_ctrl;

    localparam int N = 4;
    localparam int S = 8;
    localparam int T = 16;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [N-1:0] en_mask_i;
    logic [N-1:0] cluster_ready_i;
    logic [N-1:0] cluster_clk_en_o;
    logic [N-1:0] cluster_rst_o;
    logic         busy_o;
    logic         done_o;
    logic [N-1:0] err_mask_o;
    logic         irq_o;
    logic         irq_clr_i;

    pb_cluster_boot_ctrl #(
        .NumClusters  (N),
        .StaggerCycles(S),
        .TimeoutCycles(T)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .en_mask_i       (en_mask_i),
        .cluster_ready_i (cluster_ready_i),
        .cluster_clk_en_o(cluster_clk_en_o),
        .cluster_rst_o   (cluster_rst_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_mask_o      (err_mask_o),
        .irq_o           (irq_o),
        .irq_clr_i       (irq_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [N-1:0] exp_rst, exp_en, exp_err, m_mask;
    logic         exp_busy, exp_done, exp_irq, active;
    int           en_t[N], rel_t[N], to_t[N];
    int           done_t;
    int           lat[N];
    int           lowcnt[N];

    task automatic chk(string tag, logic [N-1:0] got, logic [N-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("cluster_rst", cluster_rst_o, exp_rst);
        chk("cluster_clk_en", cluster_clk_en_o, exp_en);
        chk("err_mask", err_mask_o, exp_err);
        chk("busy", N'(busy_o), N'(exp_busy));
        chk("done", N'(done_o), N'(exp_done));
        chk("irq", N'(irq_o), N'(exp_irq));
    endtask

    task automatic model_reset();
        exp_rst  = '1;
        exp_en   = '0;
        exp_err  = '0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_irq  = 1'b0;
        active   = 1'b0;
        done_t   = -1;
        for (int k = 0; k < N; k++) begin
            en_t[k]  = -1;
            rel_t[k] = -1;
            to_t[k]  = -1;
        end
    endtask

    // Whole-sequence timeline from the accepting cycle: per cluster, S cycles of clock
    // before release, one release cycle, then up to T wait cycles, then one select cycle.
    task automatic model_start(logic [N-1:0] msk);
        int sel;
        sel    = cyc - 1;
        m_mask = msk;
        active = 1'b1;
        for (int k = 0; k < N; k++) begin
            en_t[k]  = -1;
            rel_t[k] = -1;
            to_t[k]  = -1;
        end
        for (int k = 0; k < N; k++) begin
            if (msk[k]) begin
                en_t[k]  = sel + 1;
                rel_t[k] = sel + 1 + S;
                if (lat[k] <= T) begin
                    sel = sel + 2 + S + lat[k];
                end else begin
                    to_t[k] = sel + 2 + S + T;
                    sel     = to_t[k];
                end
            end
        end
        done_t  = sel + 1;
        exp_rst = exp_rst | msk;
        exp_en  = exp_en & ~msk;
        exp_err = exp_err & ~msk;
    endtask

    task automatic model_step(logic st, logic [N-1:0] msk, logic clr);
        exp_irq = exp_done | (exp_irq & ~clr);
        if (st && !exp_busy) model_start(msk);
        for (int k = 0; k < N; k++) begin
            if (en_t[k] == cyc) exp_en[k] = 1'b1;
            if (rel_t[k] == cyc) exp_rst[k] = 1'b0;
            if (to_t[k] == cyc) begin
                exp_rst[k] = 1'b1;
                exp_en[k]  = 1'b0;
                exp_err[k] = 1'b1;
            end
        end
        exp_done = active && (cyc == done_t);
        exp_busy = active && (cyc <= done_t);
    endtask

    // Each cluster raises ready lat cycles after its reset drops; unbooted
    // indices get random noise that the controller must ignore.
    task automatic drive_ready();
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) begin
            if (cluster_rst_o[k]) lowcnt[k] = 0;
            else if (lowcnt[k] < 100000) lowcnt[k]++;
            r[k] = (lowcnt[k] >= lat[k] + 1);
        end
        cluster_ready_i = r | (N'($urandom) & ~m_mask);
    endtask

    task automatic tick();
        logic         st;
        logic [N-1:0] msk;
        logic         clr;
        st  = start_i;
        msk = en_mask_i;
        clr = irq_clr_i;
        @(posedge clk_i);
        #1;
        cyc++;
        model_step(st, msk, clr);
        drive_ready();
        check_outputs();
    endtask

    task automatic run_seq(logic [N-1:0] msk, int l0, int l1, int l2, int l3, bit noise);
        lat       = '{l0, l1, l2, l3};
        start_i   = 1'b1;
        en_mask_i = msk;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 400 && exp_busy; i++) begin
            if (noise) begin
                start_i   = ($urandom_range(0, 7) == 0);
                en_mask_i = N'($urandom);
                irq_clr_i = ($urandom_range(0, 5) == 0);
            end
            tick();
        end
        start_i   = 1'b0;
        irq_clr_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        start_i   = 1'b0;
        irq_clr_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk_i);
        #1;
        cyc++;
        drive_ready();
        check_outputs();
        #2;
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i           = 1'b0;
        start_i         = 1'b0;
        en_mask_i       = '0;
        cluster_ready_i = '0;
        irq_clr_i       = 1'b0;
        m_mask          = '0;
        lat             = '{1, 1, 1, 1};
        for (int k = 0; k < N; k++) lowcnt[k] = 0;
        model_reset();

        // Reset values before any clock edge, then through an edge.
        #1;
        rst_i = 1'b1;
        #2;
        check_outputs();
        @(posedge clk_i);
        #1;
        check_outputs();
        #2;
        rst_i = 1'b0;
        tick();

        // Two clusters, ready three cycles after each release.
        run_seq(4'b0101, 3, 3, 3, 3, 1'b0);
        chk("final_rst_0101", cluster_rst_o, 4'b1010);

        // Empty mask: immediate done.
        run_seq(4'b0000, 3, 3, 3, 3, 1'b0);

        // Cluster 1 never ready, cluster 2 boots.
        run_seq(4'b0110, 3, 1000, 3, 3, 1'b0);
        chk("err_after_timeout", err_mask_o, 4'b0010);

        // Ready exactly at the timeout boundary, then one cycle too late.
        run_seq(4'b0011, T, T + 1, 2, 2, 1'b0);

        // Clear coinciding with done, then a late clear; start while busy ignored.
        lat       = '{2, 2, 2, 2};
        start_i   = 1'b1;
        en_mask_i = 4'b0001;
        tick();
        start_i   = 1'b1;
        en_mask_i = 4'b1111;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 100 && !exp_done; i++) tick();
        irq_clr_i = 1'b1;
        tick();
        irq_clr_i = 1'b0;
        tick();
        tick();
        irq_clr_i = 1'b1;
        tick();
        irq_clr_i = 1'b0;
        tick();

        // Abort during cluster 0's wait, then restart from the lowest index.
        lat       = '{1000, 3, 3, 3};
        start_i   = 1'b1;
        en_mask_i = 4'b0001;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < S + 4; i++) tick();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        run_seq(4'b0011, 1, 5, 3, 3, 1'b0);

        // Random masks, latencies and interference.
        for (int n = 0; n < 12; n++) begin
            int l[N];
            for (int k = 0; k < N; k++) begin
                l[k] = ($urandom_range(0, 4) == 0) ? 1000 : int'($urandom_range(1, T + 2));
            end
            run_seq(N'($urandom), l[0], l[1], l[2], l[3], 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
